// File: rtl/acc_core_mc.sv
// Multi-channel accumulator core.
// A run accepts unsigned samples into NUM_CH independent accumulators until the
// latched sample limit is reached or run_i drops. It then drains one channel
// result per cycle, in order 0..NUM_CH-1, on registered outputs.
module acc_core_mc #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned SATURATE      = 1,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run_i,
  input  logic [CNT_WIDTH-1:0]     num_cnt_i,
  input  logic                     valid_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic [IN_DATA_WIDTH-1:0] number_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [CH_W-1:0]          ch_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     ovf_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [DWIDTH-1:0]    acc_q [NUM_CH];
  logic [DWIDTH-1:0]    acc_d [NUM_CH];
  logic [NUM_CH-1:0]    flag_q, flag_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lim_q, lim_d;
  logic [CH_W-1:0]      idx_q, idx_d;

  logic                 valid_d;
  logic [CH_W-1:0]      ch_d;
  logic [DWIDTH-1:0]    result_d;
  logic                 ovf_d;

  logic                 accept;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [DWIDTH:0]      sum;

  // Next-state: run control, per-channel accumulate with overflow handling, drain index.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    idx_d   = idx_q;
    sum     = '0;
    accept  = (state_q == StRun) && run_i && valid_i && (32'(ch_i) < NUM_CH);
    cnt_inc = cnt_q + CNT_WIDTH'(1);

    case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StRun;
          for (int unsigned k = 0; k < NUM_CH; k++) acc_d[k] = '0;
          flag_d = '0;
          cnt_d  = '0;
          lim_d  = num_cnt_i;
        end
      end
      StRun: begin
        if (!run_i) begin
          // Abort: the sample offered in this cycle is dropped, partial sums drained.
          state_d = StDrain;
          idx_d   = '0;
        end else if (accept) begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_i == CH_W'(k)) begin
              sum = {1'b0, acc_q[k]} +
                    {{(DWIDTH + 1 - IN_DATA_WIDTH){1'b0}}, number_i};
              if (sum[DWIDTH]) begin
                flag_d[k] = 1'b1;
                acc_d[k]  = (SATURATE != 0) ? {DWIDTH{1'b1}} : sum[DWIDTH-1:0];
              end else begin
                acc_d[k]  = sum[DWIDTH-1:0];
              end
            end
          end
          // Limit 0 means unlimited; the counter then wraps harmlessly.
          cnt_d = cnt_inc;
          if ((lim_q != '0) && (cnt_inc == lim_q)) begin
            state_d = StDrain;
            idx_d   = '0;
          end
        end
      end
      StDrain: begin
        if (idx_q == CH_W'(NUM_CH - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-state: present the channel the next cycle will drain, using post-update sums.
  always_comb begin
    valid_d  = 1'b0;
    ch_d     = '0;
    result_d = '0;
    ovf_d    = 1'b0;
    if (state_d == StDrain) begin
      valid_d = 1'b1;
      ch_d    = idx_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (idx_d == CH_W'(k)) begin
          result_d = acc_d[k];
          ovf_d    = flag_d[k];
        end
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      for (int unsigned k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      flag_q   <= '0;
      cnt_q    <= '0;
      lim_q    <= '0;
      idx_q    <= '0;
      valid_o  <= 1'b0;
      ch_o     <= '0;
      result_o <= '0;
      ovf_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int unsigned k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
      idx_q    <= idx_d;
      valid_o  <= valid_d;
      ch_o     <= ch_d;
      result_o <= result_d;
      ovf_o    <= ovf_d;
    end
  end

  // Busy covers both the accepting and the draining phase.
  always_comb begin
    busy_o = (state_q != StIdle);
  end

endmodule

// File: doc/acc_core_mc.md
ACC_CORE_MC -- requirements
Module: acc_core_mc

Interface
REQ-001 Parameter IN_DATA_WIDTH, default 8, unsigned input sample width.
REQ-002 Parameter DWIDTH, default 16, accumulator and result width; SHALL be >= IN_DATA_WIDTH.
REQ-003 Parameter NUM_CH, default 4, number of independent accumulator channels; CH_W = max(1, clog2(NUM_CH)).
REQ-004 Parameter CNT_WIDTH, default 8, width of the sample-count limit.
REQ-005 Parameter SATURATE, default 1, 1 = clamp on overflow, 0 = wrap modulo 2^DWIDTH.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 run_i  input  1  starts a run from IDLE; holding high keeps the run alive; low aborts.
REQ-009 num_cnt_i  input  CNT_WIDTH  total accepted samples per run; sampled on IDLE->RUN; 0 = unlimited.
REQ-010 valid_i  input  1  number_i/ch_i qualifier.
REQ-011 ch_i  input  CH_W  target channel of the sample.
REQ-012 number_i  input  IN_DATA_WIDTH  unsigned sample.
REQ-013 busy_o  output  1  high in RUN and DRAIN.
REQ-014 valid_o  output  1  one-cycle strobe per drained channel result.
REQ-015 ch_o  output  CH_W  channel index of result_o.
REQ-016 result_o  output  DWIDTH  channel accumulated sum.
REQ-017 ovf_o  output  1  sticky overflow flag of channel ch_o for this run.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-019 IDLE: run_i=1 -> RUN; on that edge all NUM_CH accumulators and ovf flags cleared, sample counter cleared, num_cnt_i latched; no sample accepted on this edge.
REQ-020 RUN: sample accepted when valid_i=1, run_i=1 and ch_i < NUM_CH; acc[ch_i] += zero-extended number_i; sample counter +1.
REQ-021 valid_i with ch_i >= NUM_CH SHALL be ignored (no accumulate, no count).
REQ-022 Overflow (true sum > 2^DWIDTH-1): SATURATE=1 -> acc holds 2^DWIDTH-1; SATURATE=0 -> wraps; both set that channel's sticky ovf flag.
REQ-023 RUN -> DRAIN on the edge where an accepted sample makes the counter equal the nonzero latched limit; that sample IS accumulated.
REQ-024 RUN -> DRAIN on any edge with run_i=0 (abort); a valid_i in that cycle is not accepted; partial sums are drained.
REQ-025 Latched limit 0: RUN exits only via run_i=0; sample counter wraps silently.
REQ-026 DRAIN: for k = 0..NUM_CH-1 in consecutive cycles, valid_o=1, ch_o=k, result_o=acc[k], ovf_o=flag[k]; after channel NUM_CH-1 -> IDLE.
REQ-027 valid_o, ch_o, result_o, ovf_o SHALL be registered; first valid_o in the cycle after the RUN->DRAIN edge; drain lasts exactly NUM_CH cycles.
REQ-028 run_i during DRAIN SHALL be ignored; a new run requires run_i=1 observed in IDLE.
REQ-029 Outside DRAIN: valid_o=0, ovf_o=0, ch_o=0, result_o=0.
REQ-030 Accumulator values SHALL persist in IDLE until the next run start clears them.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, all accumulators, flags, counter, latched limit and all outputs to 0, independent of clk, including mid-RUN or mid-DRAIN.
REQ-032 After reset deasserts, the first rising edge with run_i=1 starts a run per REQ-019.

Verification
REQ-033 Defaults; run_i=1, num_cnt_i=100, valid_i=1, ch_i=0, number_i=1..100 on consecutive edges -> drain ch0=5050 ovf 0, ch1..3=0; busy_o low after 4 drain cycles.
REQ-034 Interleave ch_i=0,1,2,3 repeated, number_i=10,20,30,40, 8 samples, num_cnt_i=8 -> results 20,40,60,80 in order ch 0..3 on 4 consecutive cycles.
REQ-035 DWIDTH=8, SATURATE=1, ch0 samples 1..100 -> result 255, ovf_o=1; SATURATE=0 -> result 5050 mod 256 = 186, ovf_o=1.
REQ-036 num_cnt_i=0, 5 samples of 7 on ch2, then run_i=0 with valid_i=1 -> ch2=35 (abort-cycle sample dropped); ch_i=5 samples (NUM_CH=4) change nothing.
REQ-037 reset pulsed asynchronously mid-RUN after 3 samples -> outputs 0 and busy_o 0 without clock edge; next run drains all-zero channels except new samples.
REQ-038 run_i held high through DRAIN -> exactly NUM_CH valid_o strobes, one IDLE cycle, then new run starts with cleared accumulators.
